key_match_scanner16: RTL and testbench

Sequential 16-bit key scanner that sits directly upstream of the team's 16-bit equality comparison stage. It holds a loaded 16-bit key, accepts a stream of data words over a valid/ready handshake, and registers one equality result per word. It also produces aggregate results: match count, index of the first match, found flag and a done pulse. These aggregates are the job-level view consumed by control logic, while the per-word `out_eq` stream feeds downstream consumers.

---
 rtl/key_match_scanner16_if.sv | 32 +++
 rtl/key_match_scanner16.sv | 126 ++++++++++++
 tb/tb_key_match_scanner16.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_match_scanner16_if.sv
// Handshake and result bundle between a key scanner and its job controller / consumer.
// The slave modport is the scanner side.
interface key_match_scanner16_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
);
    logic              key_load;
    logic [DATA_W-1:0] key_in;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_eq;
    logic [CNT_W-1:0]  out_idx;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  first_idx;
    logic              found;
    logic              busy;
    logic              done;

    modport master (
        output key_load, key_in, start, len, in_valid, in_data,
        input  in_ready, out_valid, out_eq, out_idx, match_cnt, first_idx, found, busy, done
    );

    modport slave (
        input  key_load, key_in, start, len, in_valid, in_data,
        output in_ready, out_valid, out_eq, out_idx, match_cnt, first_idx, found, busy, done
    );
endinterface

// File: rtl/key_match_scanner16.sv
// Sequential key scanner: compares a stream of words against a loaded key, one registered
// result per accepted word, plus job-level match count, first-match index and done pulse.
module key_match_scanner16 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    key_match_scanner16_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  out_idx_q, out_idx_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  first_idx_q, first_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_eq_q, out_eq_d;
    logic              found_q, found_d;
    logic              in_ready_q, busy_q, done_q;
    logic              accept, word_eq;

    // in_ready_q is high exactly while the state register holds StScan.
    assign accept  = in_ready_q & bus.in_valid;
    assign word_eq = (bus.in_data == key_q);

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        len_d       = len_q;
        idx_d       = idx_q;
        out_idx_d   = out_idx_q;
        match_cnt_d = match_cnt_q;
        first_idx_d = first_idx_q;
        out_valid_d = 1'b0;
        out_eq_d    = out_eq_q;
        found_d     = found_q;

        case (state_q)
            StIdle: begin
                if (bus.key_load) begin
                    key_d = bus.key_in;
                end
                if (bus.start) begin
                    match_cnt_d = '0;
                    first_idx_d = '0;
                    found_d     = 1'b0;
                    idx_d       = '0;
                    len_d       = bus.len;
                    state_d     = (bus.len == '0) ? StDone : StScan;
                end
            end
            StScan: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_eq_d    = word_eq;
                    out_idx_d   = idx_q;
                    idx_d       = idx_q + CNT_W'(1);
                    if (word_eq) begin
                        if (!(&match_cnt_q)) begin
                            match_cnt_d = match_cnt_q + CNT_W'(1);
                        end
                        if (!found_q) begin
                            first_idx_d = idx_q;
                            found_d     = 1'b1;
                        end
                    end
                    if (idx_q == len_q - CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            key_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            out_idx_q   <= '0;
            match_cnt_q <= '0;
            first_idx_q <= '0;
            out_valid_q <= 1'b0;
            out_eq_q    <= 1'b0;
            found_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            out_idx_q   <= out_idx_d;
            match_cnt_q <= match_cnt_d;
            first_idx_q <= first_idx_d;
            out_valid_q <= out_valid_d;
            out_eq_q    <= out_eq_d;
            found_q     <= found_d;
            in_ready_q  <= (state_d == StScan);
            busy_q      <= (state_d == StScan);
            done_q      <= (state_d == StDone);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_eq    = out_eq_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.first_idx = first_idx_q;
    assign bus.found     = found_q;
endmodule

// File: tb/tb_key_match_scanner16.sv
// Randomized and directed bench for key_match_scanner16 against a job-level reference model.
module tb_key_match_scanner16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_match_scanner16_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    key_match_scanner16 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mkey;
    logic [15:0] words[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_eq"}, bus.out_eq, 0);
        check({tag, "_out_idx"}, bus.out_idx, 0);
        check({tag, "_match_cnt"}, bus.match_cnt, 0);
        check({tag, "_first_idx"}, bus.first_idx, 0);
        check({tag, "_found"}, bus.found, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
    endtask

    // Tasks start and end just after a falling edge.
    task automatic load_key(input logic [15:0] k);
        bus.key_load = 1'b1;
        bus.key_in   = k;
        @(negedge clk);
        bus.key_load = 1'b0;
        mkey = k;
    endtask

    task automatic run_job(input int unsigned n, input int unsigned gap_pct, input bit noise);
        int unsigned idx = 0;
        int unsigned cyc = 0;
        int unsigned exp_cnt = 0;
        int unsigned exp_first = 0;
        bit          exp_found = 0;
        bit          prev_acc = 0;
        bit          prev_eq = 0;
        bit          v;
        for (int i = 0; i < int'(n); i++) begin
            if (words[i] == mkey) begin
                if (!exp_found) begin
                    exp_first = i;
                    exp_found = 1;
                end
                if (exp_cnt < 65535) exp_cnt++;
            end
        end
        bus.start = 1'b1;
        bus.len   = n[15:0];
        @(negedge clk);
        bus.start    = 1'b0;
        bus.key_load = 1'b0;
        if (n == 0) begin
            check("z_done", bus.done, 1);
            check("z_out_valid", bus.out_valid, 0);
            check("z_busy", bus.busy, 0);
            check("z_in_ready", bus.in_ready, 0);
            check("z_match_cnt", bus.match_cnt, 0);
            check("z_first_idx", bus.first_idx, 0);
            check("z_found", bus.found, 0);
            @(negedge clk);
            check("z_done_after", bus.done, 0);
            check("z_out_valid_after", bus.out_valid, 0);
            return;
        end
        while (idx < n && cyc < 1000) begin
            check("in_ready", bus.in_ready, 1);
            check("busy", bus.busy, 1);
            check("done_mid", bus.done, 0);
            check("out_valid", bus.out_valid, prev_acc);
            if (prev_acc) begin
                check("out_eq", bus.out_eq, prev_eq);
                check("out_idx", bus.out_idx, idx - 1);
            end
            v = ($urandom_range(99) >= gap_pct);
            bus.in_valid = v;
            bus.in_data  = v ? words[idx] : 16'($urandom);
            if (noise) begin
                bus.key_load = 1'($urandom_range(1));
                bus.key_in   = 16'($urandom);
                bus.start    = 1'($urandom_range(1));
                bus.len      = 16'($urandom);
            end
            @(negedge clk);
            prev_acc = v;
            if (v) begin
                prev_eq = (words[idx] == mkey);
                idx++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.key_load = 1'b0;
        bus.start    = 1'b0;
        if (idx < n) check("job_timeout", idx, n);
        check("last_done", bus.done, 1);
        check("last_in_ready", bus.in_ready, 0);
        check("last_busy", bus.busy, 0);
        check("last_out_valid", bus.out_valid, 1);
        check("last_out_eq", bus.out_eq, prev_eq);
        check("last_out_idx", bus.out_idx, n - 1);
        check("match_cnt", bus.match_cnt, exp_cnt);
        check("first_idx", bus.first_idx, exp_first);
        check("found", bus.found, exp_found);
        @(negedge clk);
        check("post_done", bus.done, 0);
        check("post_out_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 0);
        check("hold_match_cnt", bus.match_cnt, exp_cnt);
        check("hold_found", bus.found, exp_found);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.key_load = 1'b0;
        bus.key_in   = '0;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus.key_load = 1'($urandom_range(1));
            bus.key_in   = 16'($urandom);
            bus.start    = 1'($urandom_range(1));
            bus.len      = 16'($urandom);
            bus.in_valid = 1'($urandom_range(1));
            bus.in_data  = 16'($urandom);
            @(negedge clk);
        end
        check_all_zero("rst");
        rst          = 1'b0;
        bus.key_load = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        mkey         = 16'h0000;
        words        = {16'h0000};
        run_job(1, 0, 0);

        load_key(16'hA5A5);
        words = {16'hA5A5, 16'h0000, 16'hA5A5, 16'hFFFF};
        run_job(4, 0, 0);

        load_key(16'h1234);
        words = {16'h1235, 16'h0234, 16'h9234};
        run_job(3, 0, 0);

        run_job(0, 0, 0);

        load_key(16'h00FF);
        words = {16'h00FF, 16'h0F0F, 16'h00FF};
        run_job(3, 50, 1);
        words = {16'h00FF};
        run_job(1, 0, 0);

        // key_load together with start: the new key applies to this job
        bus.key_load = 1'b1;
        bus.key_in   = 16'hC3C3;
        mkey         = 16'hC3C3;
        words        = {16'h00FF, 16'hC3C3};
        run_job(2, 0, 0);

        // reset after two of five words
        load_key(16'h5555);
        bus.start = 1'b1;
        bus.len   = 16'd5;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst  = 1'b0;
        mkey = 16'h0000;
        @(negedge clk);
        check("midrst_done_after", bus.done, 0);
        check("midrst_busy_after", bus.busy, 0);
        load_key(16'hBEEF);
        words = {16'h1111, 16'hBEEF, 16'hBEEF, 16'h0000, 16'hBEEE};
        run_job(5, 20, 0);

        for (int j = 0; j < 25; j++) begin
            int unsigned n;
            if ($urandom_range(3) == 0) load_key(16'($urandom));
            n = ($urandom_range(9) == 0) ? 0 : $urandom_range(12, 1);
            if ($urandom_range(4) == 0) begin
                bus.key_load = 1'b1;
                bus.key_in   = 16'($urandom);
                mkey         = bus.key_in;
            end
            words.delete();
            for (int i = 0; i < int'(n); i++) begin
                case ($urandom_range(2))
                    0:       words.push_back(mkey);
                    1:       words.push_back(mkey ^ (16'h1 << $urandom_range(15)));
                    default: words.push_back(16'($urandom));
                endcase
            end
            run_job(n, $urandom_range(60), 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
